// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  MID_SAMPLE  = 4'd7;
  localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; one-cycle tick every CLK_DIV clocks.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == TOP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: 16x oversampled 8N1 deframer with a one-byte holding register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic       rx_s1;
  logic       rx_s2;
  logic       tick;
  rx_state_t  state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       stop_sample;
  logic       good_done;
  logic       bad_done;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_serial;
      rx_s2 <= rx_s1;
    end
  end

  assign stop_sample = (state == STOP) && tick && (os_cnt == LAST_SAMPLE);
  assign good_done   = stop_sample && rx_s2;
  assign bad_done    = stop_sample && !rx_s2;
  assign rx_busy     = (state != IDLE);

  // Frame FSM: start detect, mid-bit start check, LSB-first data shift, stop sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s2) begin
            os_cnt <= '0;
            state  <= START;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == MID_SAMPLE) begin
              if (rx_s2) begin
                state <= IDLE;
              end else begin
                os_cnt  <= '0;
                bit_cnt <= '0;
                state   <= DATA;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == LAST_SAMPLE) begin
              shreg   <= {rx_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + 1'b1;
            if (os_cnt == LAST_SAMPLE) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register handoff, acknowledge, and single-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_done;
      overrun   <= 1'b0;
      if (good_done) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive half of the UART. Recovers 8N1 frames from the asynchronous `rx_serial` line by 16x oversampling, assembles bytes LSB-first, and holds each byte in an output holding register until the consumer acknowledges it. Sits between the pad-side serial input and the LSU-mapped UART register interface, mirroring the transmit path.

## Interface
- `CLK_DIV`, default 27: `clk` cycles per oversample tick (baud = f_clk / (16*CLK_DIV)); legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; the datapath is fixed at 8, so only 8 is supported.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low. Asserted at 0, released at 1.
- `rx_serial`  input  1  asynchronous serial line; idles high.
- `rx_ack`  input  1  consumer has taken `rx_data`; clears `rx_valid`.
- `rx_data`  output  8  last good received byte.
- `rx_valid`  output  1  level; `rx_data` holds an unacknowledged byte.
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low.
- `overrun`  output  1  one-cycle pulse; good frame completed while the previous byte was still unacknowledged.
- `rx_busy`  output  1  high in any state other than IDLE.

## Operation
- Input sync: two-flop synchronizer on `rx_serial`. Both flops reset to 1, so the line reads idle out of reset.
- Tick generator: a free-running counter counts 0..CLK_DIV-1. `tick` is high for one `clk` cycle when the count equals CLK_DIV-1.
- Sample counter `os_cnt` (4 bit) advances on `tick` only. Bit counter `bit_cnt` (3 bit). Shift register `shreg` (8 bit).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronized low, clear `os_cnt` and go to START. Detection does not wait for `tick`.
  - START: on the tick where `os_cnt`==7 (mid-bit), check the line.
    - Line high: false start; return to IDLE, no output.
    - Line low: clear `os_cnt`, clear `bit_cnt`, go to DATA.
  - DATA: on the tick where `os_cnt`==15, shift the line into `shreg[7]` (right shift, LSB first) and increment `bit_cnt`. After the sample with `bit_cnt`==7, go to STOP.
  - STOP: on the tick where `os_cnt`==15, sample the line.
    - Sample 1: frame is good.
    - Sample 0: pulse `frame_err`, discard `shreg`, leave `rx_data`/`rx_valid` unchanged.
    - Either way, return to IDLE.
- Good-frame handoff:
  - If `rx_valid`==0, or `rx_ack`==1 in the same cycle: load `rx_data`<=`shreg` and set `rx_valid`=1.
  - Otherwise: keep the old `rx_data`, drop the new byte, and pulse `overrun`.
- `rx_ack` while `rx_valid`==1 and no completion in that cycle: clear `rx_valid` next cycle. `rx_ack` while `rx_valid`==0 has no effect.
- Line low during IDLE right after a frame error (break condition): the FSM re-enters START and may flag further frame errors. No special break handling.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame: immediate abort to these values. The partial byte is lost.
- Latency: the synchronizer adds 2 cycles. `rx_valid` rises one `clk` after the stop-bit sample tick, i.e. about 9.5 bit times plus 3 cycles after the start-bit falling edge.
- Sampling points: each bit is sampled about 16 ticks apart, at mid-bit. Start-edge detection jitter is at most CLK_DIV cycles.
- `frame_err` and `overrun` are single-cycle registered pulses. They are mutually exclusive by construction.
- Back-to-back frames: IDLE can accept the next start edge in the cycle after STOP.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`
  - `OVERSAMPLE`=16, `MID_SAMPLE`=7, `LAST_SAMPLE`=15.
- Sub-module `uart_baud_tick`:
  - Parameter `CLK_DIV`.
  - Ports: `clk`, `reset`, `tick`.
  - Shareable with the transmit path.
- The synchronizer, FSM and holding register live in `uart_rx_core`.

## Test plan
All scenarios use CLK_DIV=4, so one bit is 64 clocks.
- Reset release with line high: all outputs at reset values; line idle for 1000 cycles leaves `rx_busy`=0 and `rx_valid`=0.
- Send 0xA5, 8N1: `rx_valid` rises with `rx_data`=0xA5, `frame_err`=0; `rx_ack` one cycle later gives `rx_valid`=0.
- Glitch low for 20 clocks, then high: false start; no `rx_valid` and no `frame_err`; `rx_busy` returns to 0.
- Send 0x3C with the stop bit forced low: `frame_err` pulses once; `rx_valid` stays 0 and `rx_data` stays 0x00.
- Send 0x11 then 0x22 with no ack: `overrun` pulses once, `rx_data`=0x11. Repeat with `rx_ack` asserted in the completion cycle of 0x22: `rx_data`=0x22, `rx_valid`=1, no `overrun`.
- Assert `reset` during data bit 4 of 0xFF: outputs return to reset values immediately. A following 0x5A is received correctly.
